// File: rtl/kmeans_reduce_tree.sv
// Pipelined adder-tree reduction of per-engine cluster accumulators and pixel counts.
// One beat per cycle; a single global enable freezes every stage under backpressure.
module kmeans_reduce_tree #(
  parameter int NUM_ENGINES = 4,
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 24,
  parameter int CNT_W       = 12,
  parameter int TAG_W       = 4,
  localparam int LEVELS     = $clog2(NUM_ENGINES),
  localparam int SUM_W      = ACC_W + LEVELS,
  localparam int CSUM_W     = CNT_W + LEVELS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_ENGINES*NUM_CH*ACC_W-1:0] in_acc,
  input  logic [NUM_ENGINES*CNT_W-1:0]      in_cnt,
  input  logic [NUM_ENGINES-1:0]            in_mask,
  input  logic [TAG_W-1:0]                  in_tag,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*SUM_W-1:0]           out_acc,
  output logic [CSUM_W-1:0]                 out_cnt,
  output logic [TAG_W-1:0]                  out_tag,
  output logic                              out_last,
  output logic                              out_empty,
  output logic                              busy
);

  // Tree nodes live in heap order: root at 0, leaves at P-1 .. 2P-2,
  // level l occupying indices (P>>l)-1 .. (2P>>l)-2.
  localparam int P     = 1 << LEVELS;
  localparam int NODES = 2 * P - 1;

  logic en;

  logic [SUM_W-1:0]  leaf_acc [P][NUM_CH];
  logic [CSUM_W-1:0] leaf_cnt [P];

  logic [SUM_W-1:0]  acc_p  [NODES][NUM_CH];
  logic [CSUM_W-1:0] cnt_p  [NODES];
  logic [LEVELS:0]   vld_p;
  logic [LEVELS:0]   last_p;
  logic [TAG_W-1:0]  tag_p  [LEVELS+1];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Masked lanes and padding lanes beyond NUM_ENGINES enter the tree as zero.
  for (genvar e = 0; e < P; e++) begin : g_leaf
    if (e < NUM_ENGINES) begin : g_real
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign leaf_acc[e][c] = in_mask[e] ? SUM_W'(in_acc[(e*NUM_CH+c)*ACC_W +: ACC_W]) : '0;
      end
      assign leaf_cnt[e] = in_mask[e] ? CSUM_W'(in_cnt[e*CNT_W +: CNT_W]) : '0;
    end else begin : g_pad
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign leaf_acc[e][c] = '0;
      end
      assign leaf_cnt[e] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p  <= '0;
      last_p <= '0;
      for (int i = 0; i <= LEVELS; i++) tag_p[i] <= '0;
      for (int n = 0; n < NODES; n++) begin
        cnt_p[n] <= '0;
        for (int c = 0; c < NUM_CH; c++) acc_p[n][c] <= '0;
      end
    end else if (en) begin
      // stage 0: input register
      vld_p[0]  <= in_valid;
      tag_p[0]  <= in_tag;
      last_p[0] <= in_last;
      for (int e = 0; e < P; e++) begin
        cnt_p[P-1+e] <= leaf_cnt[e];
        for (int c = 0; c < NUM_CH; c++) acc_p[P-1+e][c] <= leaf_acc[e][c];
      end
      // stages 1..LEVELS: pairwise add of the level below
      for (int l = 1; l <= LEVELS; l++) begin
        vld_p[l]  <= vld_p[l-1];
        tag_p[l]  <= tag_p[l-1];
        last_p[l] <= last_p[l-1];
        for (int k = 0; k < (P >> l); k++) begin
          cnt_p[(P>>l)-1+k] <= cnt_p[(P>>(l-1))-1+2*k] + cnt_p[(P>>(l-1))+2*k];
          for (int c = 0; c < NUM_CH; c++)
            acc_p[(P>>l)-1+k][c] <= acc_p[(P>>(l-1))-1+2*k][c] + acc_p[(P>>(l-1))+2*k][c];
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign out_acc[c*SUM_W +: SUM_W] = acc_p[0][c];
  end

  assign out_valid = vld_p[LEVELS];
  assign out_cnt   = cnt_p[0];
  assign out_tag   = tag_p[LEVELS];
  assign out_last  = last_p[LEVELS];
  assign out_empty = out_valid && (cnt_p[0] == '0);
  assign busy      = |vld_p;

endmodule
